// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the EX-stage multiply/divide unit:
//   `DATA_WIDTH        operand and HI/LO width (default 32)
//   OP_WIDTH           width of the mult/div op code
//   MULDIV_OP_*        op codes driven on mult_div_unit.i_op
//   muldiv_state_t     FSM state encoding (IDLE, RUN, FIX)
// Optional feature macro: MULDIV_MADD_EN. When it is defined, the op code
// grows to 4 bits, and MADD/MSUB plus their unsigned forms become legal.
// The unsigned forms are selected by bit 3 of the op code.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_pkg;

`ifdef MULDIV_MADD_EN
    localparam int OP_WIDTH = 4;
`else
    localparam int OP_WIDTH = 3;
`endif

    localparam logic [OP_WIDTH-1:0] MULDIV_OP_MULT  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] MULDIV_OP_MULTU = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] MULDIV_OP_DIV   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] MULDIV_OP_DIVU  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] MULDIV_OP_MTHI  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] MULDIV_OP_MTLO  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] MULDIV_OP_MADD  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] MULDIV_OP_MSUB  = OP_WIDTH'(7);
`ifdef MULDIV_MADD_EN
    localparam logic [OP_WIDTH-1:0] MULDIV_OP_MADDU = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] MULDIV_OP_MSUBU = OP_WIDTH'(15);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/mult_div_unit_seq_divider_core.sv
// ---------------------------------------------------------------------------
// seq_divider_core
// Restoring radix-2 divider datapath. It works on unsigned magnitudes and
// produces one quotient bit per i_step. After DATA_WIDTH steps, o_quotient
// and o_remainder hold the result.
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_load                   capture dividend/divisor, clear remainder
//   i_step                   perform one shift-subtract iteration
//   i_dividend, i_divisor    unsigned operand magnitudes
//   o_quotient, o_remainder  running quotient / partial remainder
// ---------------------------------------------------------------------------
module seq_divider_core #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic [DATA_WIDTH-1:0] o_remainder
);

    logic [DATA_WIDTH-1:0] divisor_q;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;

    // The quotient register doubles as the dividend shift register. Its MSB
    // moves into the remainder while the new quotient bit enters at the LSB.
    assign shifted = {o_remainder, o_quotient[DATA_WIDTH-1]};
    // The remainder is always below the divisor, so the top bit of diff is a
    // clean borrow flag.
    assign diff    = shifted - {1'b0, divisor_q};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            divisor_q   <= '0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else if (i_load) begin
            divisor_q   <= i_divisor;
            o_quotient  <= i_dividend;
            o_remainder <= '0;
        end else if (i_step) begin
            if (!diff[DATA_WIDTH]) begin
                o_remainder <= diff[DATA_WIDTH-1:0];
                o_quotient  <= {o_quotient[DATA_WIDTH-2:0], 1'b1};
            end else begin
                o_remainder <= shifted[DATA_WIDTH-1:0];
                o_quotient  <= {o_quotient[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative EX-stage multiply/divide unit that owns the HI/LO registers.
// It executes MULT/MULTU/DIV/DIVU one bit per cycle, and MTHI/MTLO in a
// single cycle.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start, i_op       issue strobe and op code (mips_pkg MULDIV_OP_*)
//   i_operand_a/b       rs / rt values
//   i_flush             squash the in-flight operation
//   o_hi, o_lo          HI / LO registers
//   o_busy              operation in flight (registered)
//   o_done              one-cycle pulse when HI/LO take a mult/div result
//   o_state             FSM state, for debug
// Optional feature macro: MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which
// accumulate into {HI,LO}.
//
// Issue protocol: i_start is sampled only in IDLE, and only when i_flush is
// low. Ops that take several cycles raise o_busy at the next edge. o_busy
// stays high until the edge that writes HI/LO, and that edge also pulses
// o_done. i_start while o_busy=1 is dropped.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [OP_WIDTH-1:0]   i_op,
    input  logic [DATA_WIDTH-1:0] i_operand_a,
    input  logic [DATA_WIDTH-1:0] i_operand_b,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_busy,
    output logic                  o_done,
    output muldiv_state_t         o_state
);

    localparam int PW = 2 * DATA_WIDTH;

    muldiv_state_t         state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  is_div, div_zero, sign_a, sign_b;
    logic [DATA_WIDTH-1:0] mcand, orig_a;
    logic [PW-1:0]         prod;
`ifdef MULDIV_MADD_EN
    logic                  acc_add, acc_sub;
`endif

    // Op decode, used only while IDLE
    logic dec_mul, dec_div, dec_signed, dec_add, dec_sub;
    always_comb begin
        dec_mul    = 1'b0;
        dec_div    = 1'b0;
        dec_signed = 1'b0;
        dec_add    = 1'b0;
        dec_sub    = 1'b0;
        case (i_op)
            MULDIV_OP_MULT:  begin dec_mul = 1'b1; dec_signed = 1'b1; end
            MULDIV_OP_MULTU: dec_mul = 1'b1;
            MULDIV_OP_DIV:   begin dec_div = 1'b1; dec_signed = 1'b1; end
            MULDIV_OP_DIVU:  dec_div = 1'b1;
`ifdef MULDIV_MADD_EN
            MULDIV_OP_MADD:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_add = 1'b1; end
            MULDIV_OP_MADDU: begin dec_mul = 1'b1; dec_add = 1'b1; end
            MULDIV_OP_MSUB:  begin dec_mul = 1'b1; dec_signed = 1'b1; dec_sub = 1'b1; end
            MULDIV_OP_MSUBU: begin dec_mul = 1'b1; dec_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    logic                  a_neg, b_neg, issue, b_zero;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    assign a_neg  = dec_signed & i_operand_a[DATA_WIDTH-1];
    assign b_neg  = dec_signed & i_operand_b[DATA_WIDTH-1];
    assign a_mag  = a_neg ? -i_operand_a : i_operand_a;
    assign b_mag  = b_neg ? -i_operand_b : i_operand_b;
    assign issue  = (state == ST_IDLE) && i_start && !i_flush;
    assign b_zero = (i_operand_b == '0);

    // Shift-add step: the multiplier sits in the low half of prod and is
    // consumed LSB-first, while partial sums accumulate in the high half.
    logic [DATA_WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, prod[PW-1:DATA_WIDTH]}
                   + (prod[0] ? {1'b0, mcand} : {(DATA_WIDTH+1){1'b0}});

    logic [DATA_WIDTH-1:0] quo, rem;
    seq_divider_core #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (issue && dec_div && !b_zero),
        .i_step      ((state == ST_RUN) && is_div),
        .i_dividend  (a_mag),
        .i_divisor   (b_mag),
        .o_quotient  (quo),
        .o_remainder (rem)
    );

    // Sign correction and result selection, applied during FIX
    logic [PW-1:0]         prod_s, fix_hilo;
    logic [DATA_WIDTH-1:0] quo_s, rem_s;
    assign prod_s = (sign_a ^ sign_b) ? -prod : prod;
    assign quo_s  = (sign_a ^ sign_b) ? -quo  : quo;
    assign rem_s  = sign_a ? -rem : rem;

    always_comb begin
        fix_hilo = prod_s;
        if (is_div) begin
            fix_hilo = div_zero ? {orig_a, {DATA_WIDTH{1'b1}}} : {rem_s, quo_s};
        end
`ifdef MULDIV_MADD_EN
        else if (acc_add) fix_hilo = {o_hi, o_lo} + prod_s;
        else if (acc_sub) fix_hilo = {o_hi, o_lo} - prod_s;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mcand    <= '0;
            orig_a   <= '0;
            prod     <= '0;
            o_hi     <= '0;
            o_lo     <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_add  <= 1'b0;
            acc_sub  <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue && (dec_mul || dec_div)) begin
                        is_div   <= dec_div;
                        sign_a   <= a_neg;
                        sign_b   <= b_neg;
                        mcand    <= a_mag;
                        prod     <= {{DATA_WIDTH{1'b0}}, b_mag};
                        orig_a   <= i_operand_a;
                        cnt      <= CNT_WIDTH'(DATA_WIDTH);
                        o_busy   <= 1'b1;
`ifdef MULDIV_MADD_EN
                        acc_add  <= dec_add;
                        acc_sub  <= dec_sub;
`endif
                        div_zero <= dec_div && b_zero;
                        state    <= (dec_div && b_zero) ? ST_FIX : ST_RUN;
                    end else if (issue && i_op == MULDIV_OP_MTHI) begin
                        o_hi <= i_operand_a;
                    end else if (issue && i_op == MULDIV_OP_MTLO) begin
                        o_lo <= i_operand_a;
                    end
                end
                ST_RUN: begin
                    if (i_flush) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (!is_div) prod <= {mul_sum, prod[DATA_WIDTH-1:1]};
                        if (cnt == CNT_WIDTH'(1)) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                    if (!i_flush) begin
                        {o_hi, o_lo} <= fix_hilo;
                        o_done       <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule
